// File: rtl/seg_scan_if.sv
// Display-side interface of seg_scan_ctrl: value and display controls in,
// multiplexed digit code, active-low digit select and converter status out.
interface seg_scan_if #(
  parameter int NUM_DIG = 6,
  parameter int BIN_W   = 20
);
  logic [BIN_W-1:0]   data;
  logic               en;
  logic               blank_lz;
  logic [3:0]         data_disp;
  logic [NUM_DIG-1:0] seg_sel;
  logic               busy;

  modport master (
    output data, en, blank_lz,
    input  data_disp, seg_sel, busy
  );

  modport slave (
    input  data, en, blank_lz,
    output data_disp, seg_sel, busy
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a time-multiplexed
// digit scanner for a 7-segment decoder; code 4'hf renders blank.
module seg_scan_ctrl #(
  parameter int NUM_DIG = 6,
  parameter int BIN_W   = 20,
  parameter int CLK_DIV = 50000
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  seg_scan_if.slave bus
);
  localparam int BCD_DIG = 6;              // 999999 needs six BCD digits
  localparam int BCD_W   = 4 * BCD_DIG;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(999_999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     load, shift_en, commit;
  logic [BIN_W-1:0]         snap_q, shift_q;
  logic [BCD_W-1:0]         acc_q, acc_adj;
  logic [CNT_W-1:0]         cnt_q;
  logic                     busy_q;
  logic [NUM_DIG-1:0][3:0]  digit_q;
  logic [DIV_W-1:0]         div_q;
  logic [IDX_W-1:0]         idx_q;
  logic [NUM_DIG-1:0]       blank_vec;
  logic                     nz_above;
  logic [3:0]               disp_q;
  logic [NUM_DIG-1:0]       sel_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.data != snap_q) begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble correction applied before each shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: the digit registers are a handful of flops, not a RAM, so they sit on
  // the async reset like the rest of the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap_q  <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      digit_q <= '0;
    end else begin
      if (load) begin
        snap_q  <= bus.data;
        shift_q <= (bus.data > MAX_VAL) ? MAX_VAL : bus.data;
        acc_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
      if (shift_en) begin
        {acc_q, shift_q} <= {acc_adj, shift_q} << 1;
        cnt_q            <= cnt_q + CNT_W'(1);
      end
      if (commit) begin
        digit_q <= acc_q[4*NUM_DIG-1:0];
        busy_q  <= 1'b0;
      end
    end
  end

  // Digit k>0 is blanked when it and every higher digit are zero.
  always_comb begin
    blank_vec = '0;
    nz_above  = 1'b0;
    for (int k = NUM_DIG - 1; k > 0; k--) begin
      nz_above     = nz_above | (digit_q[k] != 4'd0);
      blank_vec[k] = bus.blank_lz & ~nz_above;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Select and code are registered together so they never disagree.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      disp_q <= 4'hf;
      sel_q  <= '1;
    end else if (!bus.en) begin
      disp_q <= 4'hf;
      sel_q  <= '1;
    end else begin
      sel_q  <= ~(NUM_DIG'(1) << idx_q);
      disp_q <= blank_vec[idx_q] ? 4'hf : digit_q[idx_q];
    end
  end

  assign bus.data_disp = disp_q;
  assign bus.seg_sel   = sel_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected conversions are queued when data
// is driven; a monitor checks every scan output against a decimal display model.
module tb_seg_scan_ctrl;
  localparam int NUM_DIG = 6;
  localparam int BIN_W   = 20;
  localparam int CLK_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIG(NUM_DIG), .BIN_W(BIN_W)) bus ();

  seg_scan_ctrl #(.NUM_DIG(NUM_DIG), .BIN_W(BIN_W), .CLK_DIV(CLK_DIV)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned exp_q[$];
  int unsigned last_data = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic int unsigned pow10(input int k);
    int unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // ---------------- monitor / reference model ----------------
  int          n_edge;
  int unsigned shown;
  logic        en_prev, bl_prev, busy_prev;
  int          busy_len, wait_cnt;

  always @(negedge clk) begin
    int                 idx;
    logic [NUM_DIG-1:0] e_sel;
    logic [3:0]         e_disp;
    int unsigned        v;
    if (!rst_n) begin
      check("rst_data_disp", bus.data_disp, 4'hf);
      check("rst_seg_sel", bus.seg_sel, {NUM_DIG{1'b1}});
      check("rst_busy", bus.busy, 0);
      n_edge = 0; shown = 0; busy_prev = 1'b0; busy_len = 0; wait_cnt = 0;
    end else begin
      n_edge++;
      // Output seen now was built from the slot index after the previous edge.
      idx = ((n_edge - 1) / CLK_DIV) % NUM_DIG;
      if (!en_prev) begin
        e_sel  = '1;
        e_disp = 4'hf;
      end else begin
        e_sel = ~(NUM_DIG'(1) << idx);
        if (bl_prev && idx > 0 && shown < pow10(idx)) e_disp = 4'hf;
        else e_disp = 4'((shown / pow10(idx)) % 10);
      end
      check("seg_sel", bus.seg_sel, e_sel);
      check("data_disp", bus.data_disp, e_disp);

      if (bus.busy) busy_len++;
      if (bus.busy && !busy_prev) check("busy_rise_expected", exp_q.size() > 0, 1);
      if (!bus.busy && busy_prev) begin
        check("busy_len", busy_len, BIN_W + 1);
        busy_len = 0;
        if (exp_q.size() == 0) begin
          check("result_expected", 0, 1);
        end else begin
          v     = exp_q.pop_front();
          shown = sat(v);
          wait_cnt = 0;
        end
      end
      if (exp_q.size() > 0) wait_cnt++;
      else wait_cnt = 0;
      if (wait_cnt > 3 * (BIN_W + 2)) begin
        n_checks++;
        $display("FAIL conv_timeout: no result after %0d cycles, %0d pending", wait_cnt, exp_q.size());
        exp_q.delete();
        wait_cnt = 0;
      end
      busy_prev = bus.busy;
    end
    en_prev = bus.en;
    bl_prev = bus.blank_lz;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_data(input int unsigned v);
    if (v != last_data) exp_q.push_back(v);
    last_data = v;
    bus.data  = BIN_W'(v);
  endtask

  initial begin
    int unsigned v;
    int          w;
    bus.data = '0; bus.en = 1'b1; bus.blank_lz = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst0_data_disp", bus.data_disp, 4'hf);
    check("rst0_seg_sel", bus.seg_sel, {NUM_DIG{1'b1}});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    tick(2 * NUM_DIG * CLK_DIV + 2);          // value 0: single "0", rest blank
    set_data(123456);   tick(60);
    set_data(1048575);  tick(50);              // saturates to 999999
    set_data(1200);     tick(50);
    bus.blank_lz = 1'b0; tick(30);
    bus.blank_lz = 1'b1;
    set_data(5); tick(3); set_data(77); tick(70);
    tick(7); bus.en = 1'b0; tick(9); bus.en = 1'b1; tick(30);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 999999);
        default: v = $urandom_range(0, (1 << BIN_W) - 1);
      endcase
      set_data(v);
      bus.blank_lz = 1'($urandom_range(0, 1));
      w = $urandom_range(25, 45);
      for (int c = 0; c < w; c++) begin
        tick(1);
        if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
      end
      bus.en = 1'b1;
      tick(NUM_DIG * CLK_DIV);
    end

    // Reset in the middle of a conversion.
    set_data((last_data == 424242) ? 424243 : 424242);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_data_disp", bus.data_disp, 4'hf);
    check("midrst_seg_sel", bus.seg_sel, {NUM_DIG{1'b1}});
    check("midrst_busy", bus.busy, 0);
    exp_q.delete();
    last_data = 0;
    set_data(bus.data);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(2 * NUM_DIG * CLK_DIV + 40);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Upstream feeder for the 7-segment decoder. Converts a binary score/value to packed BCD with a sequential double-dabble engine. Time-multiplexes the digits onto one 4-bit data_disp bus plus an active-low digit-select vector; the decoder turns data_disp into segments. Codes 4'ha-4'hf render blank at the decoder, so 4'hf is the blank code.

Parameters:
NUM_DIG, 6, number of digits scanned (1..6); digit 0 = least significant
BIN_W, 20, width of binary input; must hold 999999
CLK_DIV, 50000, sys_clk cycles per digit slot (1 kHz slot rate at 50 MHz); minimum 2

Ports:
sys_clk  input  1  system clock, all logic rising-edge
sys_rst_n  input  1  asynchronous active-low reset
data  input  BIN_W  binary value to display, sampled only when the converter is idle
en  input  1  display enable; 0 turns all digits off, conversion continues
blank_lz  input  1  1 = blank leading zeros
data_disp  output  4  BCD digit code to decoder; 4'hf = blank
seg_sel  output  NUM_DIG  digit select, active-low, one-cold
busy  output  1  converter running

Behaviour:
- Reset (async assert, sync release): data_disp=4'hf, seg_sel=all ones, busy=0, digit regs=0, snapshot=0, scan idx=0, div counter=0, FSM=IDLE.
- Converter FSM: IDLE, SHIFT, DONE.
  - IDLE: if data != snapshot -> snapshot<=data, load shift reg (saturated: data>999999 loads 999999), BCD acc<=0, count<=0, busy<=1, go SHIFT. Otherwise stay.
  - SHIFT: per cycle, every BCD nibble >=5 gets +3, then {acc,shift} shifts left 1 (both in the same cycle). After BIN_W shifts go DONE.
  - DONE: copy the NUM_DIG nibbles to digit regs atomically, busy<=0, go IDLE.
  - Latency: data change to digit regs updated = BIN_W+2 cycles (22 at default). Display never shows partial results.
  - data changing during SHIFT/DONE is ignored. On return to IDLE it is compared against snapshot, so a new conversion starts the next cycle. No value is lost except intermediate ones.
  - Snapshot stores the raw data, not the saturated value.
- Scan:
  - div counter counts 0..CLK_DIV-1 and wraps.
  - On the wrap cycle, idx advances 0..NUM_DIG-1 and wraps to 0.
  - data_disp and seg_sel are registered and update together one cycle after idx changes. No cycle exists where the select and the code disagree.
  - seg_sel = ~(1<<idx) when en=1; all ones when en=0.
  - data_disp = digit[idx], or 4'hf when en=0 or when the digit is blanked.
  - Blanking: with blank_lz=1, digit k>0 is blanked if it and all higher digits are zero. Digit 0 is never blanked, so the value 0 shows a single "0".
- en toggling does not reset idx or the divider. The scan keeps running.
- Reset mid-conversion aborts it. Digits return to 0 and the next IDLE cycle reconverts the current data, since snapshot=0 differs from any nonzero data.

Test Plan:
- Reset then data=0, en=1, blank_lz=1, CLK_DIV=4: no conversion started (busy stays 0). Slot 0 shows data_disp=0, seg_sel=6'b111110. Slots 1-5 show 4'hf with their select lines low in turn.
- data=123456: busy high exactly 21 cycles (SHIFT 20 + DONE 1). Digit regs = 6,5,4,3,2,1 after cycle 22. Scan outputs 6,5,4,3,2,1 on seg_sel 111110..011111.
- data=1048575 (overflow): all six digits display 9.
- data=1200, blank_lz=1: digits 0..3 show 0,0,2,1; digits 4,5 show 4'hf. With blank_lz=0, digits 4,5 show 0.
- Change data from 5 to 77 at cycle 3 of a conversion: the first result is 5, then busy reasserts the next cycle and the final digits are 7,7.
- en=0 mid-scan: seg_sel=all ones and data_disp=4'hf within 1 cycle. Re-enable: idx continues from its running value. Async reset asserted mid-SHIFT: outputs are at reset values immediately.
